// File: rtl/lane_queue_model_pkg.sv
// Shared lane definitions for the lane queue traffic-plant model.
package lane_queue_model_pkg;

  localparam int unsigned NUM_LANES = 8;

  localparam int unsigned LANE_S1 = 0;
  localparam int unsigned LANE_S2 = 1;
  localparam int unsigned LANE_E1 = 2;
  localparam int unsigned LANE_E2 = 3;
  localparam int unsigned LANE_N1 = 4;
  localparam int unsigned LANE_N2 = 5;
  localparam int unsigned LANE_W1 = 6;
  localparam int unsigned LANE_W2 = 7;

  typedef enum logic [1:0] {
    RED,
    STARTUP,
    FLOW
  } laneState_t;

  // Slot (counted from the LSB) that a lane occupies on the packed
  // Breadboard lane bus {w1,w2,s1,s2,e1,e2,n1,n2}.
  function automatic int unsigned laneSlot(input int unsigned lane);
    case (lane)
      LANE_W1: return 7;
      LANE_W2: return 6;
      default: return 5 - lane;
    endcase
  endfunction

endpackage

// File: rtl/lane_queue_model_cell.sv
// One lane: green-light FSM, departure timer and saturating vehicle counter.
module lane_queue_cell
  import lane_queue_model_pkg::*;
#(
  parameter int unsigned COUNT_W         = 8,
  parameter int unsigned START_DELAY     = 2,
  parameter int unsigned DEPART_INTERVAL = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               green,
  input  logic               arrive,
  input  logic               inject,
  input  logic               load,
  input  logic [COUNT_W-1:0] loadVal,
  output logic [COUNT_W-1:0] count,
  output logic [COUNT_W-1:0] countNext,
  output logic               depart
);

  localparam int unsigned MAX_DELAY = (START_DELAY > DEPART_INTERVAL) ? START_DELAY : DEPART_INTERVAL;
  localparam int unsigned TIMER_W   = $clog2(MAX_DELAY + 1);
  localparam int unsigned SUM_W     = COUNT_W + 2;

  laneState_t         state;
  logic [TIMER_W-1:0] timer;
  logic [SUM_W-1:0]   sum;

  // Departure decision and next count (load wins, otherwise saturating add/sub).
  always_comb begin
    depart = green && (state != RED) && (timer == '0) && (count != '0) && !load;
    sum    = SUM_W'(count) + SUM_W'(arrive) + SUM_W'(inject) - SUM_W'(depart);
    if (load) begin
      countNext = loadVal;
    end else if (sum > SUM_W'({COUNT_W{1'b1}})) begin
      countNext = '1;
    end else begin
      countNext = sum[COUNT_W-1:0];
    end
  end

  // Lane state, timer and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RED;
      timer <= '0;
      count <= '0;
    end else begin
      count <= countNext;
      if (!green) begin
        state <= RED;
        timer <= '0;
      end else begin
        case (state)
          RED: begin
            state <= STARTUP;
            timer <= TIMER_W'(START_DELAY - 1);
          end
          STARTUP: begin
            if (timer == '0) begin
              state <= FLOW;
              timer <= TIMER_W'(DEPART_INTERVAL - 1);
            end else begin
              timer <= timer - 1'b1;
            end
          end
          FLOW: begin
            if (timer == '0) begin
              timer <= TIMER_W'(DEPART_INTERVAL - 1);
            end else begin
              timer <= timer - 1'b1;
            end
          end
          default: begin
            state <= RED;
            timer <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/lane_queue_model.sv
// Closed-loop traffic plant: eight lane queues, emergency tracker and
// departure tally, presenting counts on the Breadboard lane bus.
module lane_queue_model
  import lane_queue_model_pkg::*;
#(
  parameter int unsigned COUNT_W         = 8,
  parameter int unsigned START_DELAY     = 2,
  parameter int unsigned DEPART_INTERVAL = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             green,
  input  logic [7:0]             arrive,
  input  logic                   load_en,
  input  logic [8*COUNT_W-1:0]   load_counts,
  input  logic                   emg_inject,
  input  logic [2:0]             emg_inject_lane,
  output logic [8*COUNT_W-1:0]   lane_counts,
  output logic                   emg_signal,
  output logic [7:0]             emg_lane,
  output logic                   emg_busy,
  output logic [15:0]            total_departed
);

  logic [COUNT_W-1:0] counts     [NUM_LANES];
  logic [COUNT_W-1:0] countsNext [NUM_LANES];
  logic [7:0]         departVec;
  logic [7:0]         injectVec;
  logic [3:0]         departCount;
  logic               acceptInject;
  logic               emgDepart;
  logic [2:0]         emgIdx;
  logic [COUNT_W-1:0] emgRemaining;

  for (genvar i = 0; i < NUM_LANES; i++) begin : gLane
    localparam int unsigned SLOT = laneSlot(i);

    lane_queue_cell #(
      .COUNT_W        (COUNT_W),
      .START_DELAY    (START_DELAY),
      .DEPART_INTERVAL(DEPART_INTERVAL)
    ) uCell (
      .clk      (clk),
      .rst      (rst),
      .green    (green[i]),
      .arrive   (arrive[i]),
      .inject   (injectVec[i]),
      .load     (load_en),
      .loadVal  (load_counts[SLOT*COUNT_W +: COUNT_W]),
      .count    (counts[i]),
      .countNext(countsNext[i]),
      .depart   (departVec[i])
    );

    assign lane_counts[SLOT*COUNT_W +: COUNT_W] = counts[i];
  end

  // Injection steering and departure popcount.
  always_comb begin
    acceptInject = emg_inject && !emg_signal && !load_en;
    injectVec    = '0;
    if (acceptInject) begin
      injectVec[emg_inject_lane] = 1'b1;
    end
    departCount = '0;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      departCount = departCount + 4'(departVec[k]);
    end
    emgDepart = departVec[emgIdx];
  end

  // Emergency tracking and departure tally.
  always_ff @(posedge clk) begin
    if (rst) begin
      emg_signal     <= 1'b0;
      emg_lane       <= '0;
      emg_busy       <= 1'b0;
      total_departed <= '0;
      emgIdx         <= '0;
      emgRemaining   <= '0;
    end else begin
      emg_busy       <= emg_inject && emg_signal && !load_en;
      total_departed <= total_departed + {12'b0, departCount};
      if (load_en) begin
        emg_signal   <= 1'b0;
        emg_lane     <= '0;
        emgRemaining <= '0;
      end else if (acceptInject) begin
        // Remaining is the lane's post-update count, so a coincident arrival is included.
        emg_signal   <= 1'b1;
        emg_lane     <= 8'b1 << emg_inject_lane;
        emgIdx       <= emg_inject_lane;
        emgRemaining <= countsNext[emg_inject_lane];
      end else if (emg_signal && emgDepart) begin
        emgRemaining <= emgRemaining - 1'b1;
        if (emgRemaining == COUNT_W'(1)) begin
          emg_signal <= 1'b0;
          emg_lane   <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_lane_queue_model.sv
// Self-checking bench for lane_queue_model against a behavioural queue model.
module tb_lane_queue_model;

  localparam int SD = 2;
  localparam int DI = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  green = '0;
  logic [7:0]  arrive = '0;
  logic        load_en = 1'b0;
  logic [63:0] load_counts = '0;
  logic        emg_inject = 1'b0;
  logic [2:0]  emg_inject_lane = '0;
  logic [63:0] lane_counts;
  logic        emg_signal;
  logic [7:0]  emg_lane;
  logic        emg_busy;
  logic [15:0] total_departed;

  lane_queue_model #(
    .COUNT_W        (8),
    .START_DELAY    (SD),
    .DEPART_INTERVAL(DI)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .green          (green),
    .arrive         (arrive),
    .load_en        (load_en),
    .load_counts    (load_counts),
    .emg_inject     (emg_inject),
    .emg_inject_lane(emg_inject_lane),
    .lane_counts    (lane_counts),
    .emg_signal     (emg_signal),
    .emg_lane       (emg_lane),
    .emg_busy       (emg_busy),
    .total_departed (total_departed)
  );

  always #5 clk = ~clk;

  // Behavioural model state: run = green edges seen so far in the current streak.
  int mCount [8];
  int mRun   [8];
  int mSig, mLane, mRem, mBusy, mTotal;
  int nCompared = 0;
  int nMismatched = 0;
  logic checkEn = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int busLane(input logic [63:0] bus, input int lane);
    case (lane)
      0: return int'(bus[47:40]);
      1: return int'(bus[39:32]);
      2: return int'(bus[31:24]);
      3: return int'(bus[23:16]);
      4: return int'(bus[15:8]);
      5: return int'(bus[7:0]);
      6: return int'(bus[63:56]);
      default: return int'(bus[55:48]);
    endcase
  endfunction

  function automatic logic [63:0] expBus();
    return {8'(mCount[6]), 8'(mCount[7]), 8'(mCount[0]), 8'(mCount[1]),
            8'(mCount[2]), 8'(mCount[3]), 8'(mCount[4]), 8'(mCount[5])};
  endfunction

  task automatic modelStep();
    int dep [8];
    int nd, nc;
    bit accept;
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        mCount[i] = 0;
        mRun[i] = 0;
      end
      mSig = 0; mLane = 0; mRem = 0; mBusy = 0; mTotal = 0;
      return;
    end
    accept = emg_inject && (mSig == 0) && !load_en;
    mBusy  = (emg_inject && (mSig != 0) && !load_en) ? 1 : 0;
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      dep[i] = 0;
      if (green[i]) begin
        if (mRun[i] >= SD && ((mRun[i] - SD) % DI) == 0 && mCount[i] > 0 && !load_en) dep[i] = 1;
        mRun[i]++;
      end else begin
        mRun[i] = 0;
      end
      if (load_en) begin
        nc = busLane(load_counts, i);
      end else begin
        nc = mCount[i] + int'(arrive[i]) + ((accept && int'(emg_inject_lane) == i) ? 1 : 0) - dep[i];
        if (nc > 255) nc = 255;
      end
      mCount[i] = nc;
      nd += dep[i];
    end
    mTotal = (mTotal + nd) % 65536;
    if (load_en) begin
      mSig = 0; mRem = 0;
    end else if (accept) begin
      mSig = 1;
      mLane = int'(emg_inject_lane);
      mRem = mCount[mLane];
    end else if (mSig != 0 && dep[mLane] != 0) begin
      mRem--;
      if (mRem == 0) mSig = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      check("lane_counts", lane_counts, expBus());
      check("emg_signal", 64'(emg_signal), 64'(mSig));
      check("emg_lane", 64'(emg_lane), (mSig != 0) ? (64'd1 << mLane) : 64'd0);
      check("emg_busy", 64'(emg_busy), 64'(mBusy));
      check("total_departed", 64'(total_departed), 64'(mTotal));
    end
  end

  task automatic doLoad(input logic [63:0] bus);
    load_counts = bus;
    load_en = 1'b1;
    tick();
    load_en = 1'b0;
  endtask

  initial begin
    logic [63:0] rbus;
    rst = 1'b1;
    tick();
    checkEn = 1'b1;
    tick();
    rst = 1'b0;
    check("reset_counts", lane_counts, 64'd0);
    check("reset_total", 64'(total_departed), 64'd0);
    check("reset_emg", 64'({emg_signal, emg_lane, emg_busy}), 64'd0);

    // Drain timing: s1=5, departures at E0+2, +5, +8, +11, +14.
    doLoad(64'h0000_0500_0000_0000);
    green = 8'h01;
    for (int j = 0; j < 20; j++) begin
      tick();
      if (j == 1) check("drain_j1", 64'(lane_counts[47:40]), 64'd5);
      if (j == 2) check("drain_j2", 64'(lane_counts[47:40]), 64'd4);
      if (j == 4) check("drain_j4", 64'(lane_counts[47:40]), 64'd4);
      if (j == 5) check("drain_j5", 64'(lane_counts[47:40]), 64'd3);
      if (j == 14) check("model_drain_j14", 64'(mCount[0]), 64'd0);
    end
    check("drain_total", 64'(total_departed), 64'd5);
    check("drain_empty", 64'(lane_counts[47:40]), 64'd0);

    // Green drop after four green edges, then re-raise.
    green = 8'h00;
    doLoad(64'h0000_0500_0000_0000);
    green = 8'h01;
    for (int j = 0; j < 4; j++) tick();
    green = 8'h00;
    for (int j = 0; j < 6; j++) tick();
    check("drop_single", 64'(lane_counts[47:40]), 64'd4);
    green = 8'h01;
    tick();
    tick();
    check("reraise_j1", 64'(lane_counts[47:40]), 64'd4);
    tick();
    check("reraise_j2", 64'(lane_counts[47:40]), 64'd3);
    green = 8'h00;

    // Saturation on w2 and arrive-with-depart on n1.
    doLoad(64'h00FF_0000_0000_0300);
    green = 8'h10;
    for (int j = 0; j < 6; j++) begin
      arrive = (j == 2) ? 8'h90 : 8'h80;
      tick();
      if (j == 2) check("n1_arrive_depart", 64'(lane_counts[15:8]), 64'd3);
    end
    arrive = 8'h00;
    green = 8'h00;
    check("w2_saturated", 64'(lane_counts[55:48]), 64'd255);
    check("n1_after", 64'(lane_counts[15:8]), 64'd2);

    // Emergency on e2.
    doLoad(64'h0000_0000_0002_0000);
    emg_inject = 1'b1;
    emg_inject_lane = 3'd3;
    tick();
    check("emg_e2_count", 64'(lane_counts[23:16]), 64'd3);
    check("emg_lane_set", 64'(emg_lane), 64'h08);
    check("emg_signal_set", 64'(emg_signal), 64'd1);
    tick();
    emg_inject = 1'b0;
    check("emg_busy_pulse", 64'(emg_busy), 64'd1);
    check("emg_busy_nochange", 64'(lane_counts[23:16]), 64'd3);
    tick();
    check("emg_busy_clear", 64'(emg_busy), 64'd0);
    green = 8'h08;
    for (int j = 0; j < 9; j++) begin
      tick();
      if (j == 5) check("emg_still_active", 64'(emg_signal), 64'd1);
    end
    check("emg_cleared", 64'({emg_signal, emg_lane}), 64'd0);
    check("emg_e2_empty", 64'(lane_counts[23:16]), 64'd0);
    green = 8'h00;

    // Load override while emergency active.
    emg_inject = 1'b1;
    emg_inject_lane = 3'd0;
    tick();
    emg_inject = 1'b0;
    arrive = 8'hFF;
    doLoad(64'h1122_3344_5566_7788);
    arrive = 8'h00;
    check("load_exact", lane_counts, 64'h1122_3344_5566_7788);
    check("load_emg_clear", 64'(emg_signal), 64'd0);

    // Reset mid-flow, then startup delay after green resumes.
    doLoad(64'h0505_0505_0505_0505);
    green = 8'hFF;
    for (int j = 0; j < 6; j++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_counts", lane_counts, 64'd0);
    check("midrst_total", 64'(total_departed), 64'd0);
    check("midrst_emg", 64'(emg_signal), 64'd0);
    doLoad(64'h0505_0505_0505_0505);
    tick();
    check("resume_j1", lane_counts, 64'h0505_0505_0505_0505);
    tick();
    check("resume_j2", lane_counts, 64'h0404_0404_0404_0404);

    // Randomized closed-loop traffic.
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 8; i++) if ($urandom_range(0, 7) == 0) green[i] = ~green[i];
      arrive = 8'($urandom) & 8'($urandom);
      emg_inject = ($urandom_range(0, 29) == 0);
      emg_inject_lane = 3'($urandom);
      load_en = ($urandom_range(0, 99) == 0);
      for (int k = 0; k < 8; k++)
        rbus[k*8 +: 8] = $urandom_range(0, 1) ? 8'($urandom_range(250, 255)) : 8'($urandom);
      load_counts = rbus;
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    load_en = 1'b0;
    emg_inject = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
